// File: rtl/bram_pingpong_ctrl_if.sv
// Stream (valid/ready) and simple-dual-port BRAM bundles used by bram_pingpong_ctrl.
interface pp_stream_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] data;
    logic                  valid;
    logic                  ready;

    modport master (output data, output valid, input ready);
    modport slave  (input data, input valid, output ready);
endinterface

interface pp_bram_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 19
);
    logic [ADDR_WIDTH-1:0] addr_a;
    logic [DATA_WIDTH-1:0] din_a;
    logic                  en_a;
    logic [ADDR_WIDTH-1:0] addr_b;
    logic                  en_b;
    logic                  regce_b;
    logic [DATA_WIDTH-1:0] dout_b;

    modport master (output addr_a, output din_a, output en_a, output addr_b,
                    output en_b, output regce_b, input dout_b);
    modport slave  (input addr_a, input din_a, input en_a, input addr_b,
                    input en_b, input regce_b, output dout_b);
endinterface

// File: rtl/bram_pingpong_ctrl.sv
// Two-bank ping-pong frame buffer sequencer for a simple-dual-port BRAM.
// Defining BRAM_PP_FRAME_CNT_EN adds oFrameCnt, a wrapping count of oFrameDone pulses.
module bram_pingpong_ctrl #(
    parameter int DATA_WIDTH   = 8,
    parameter int FRAME_LEN    = 100,
    parameter int ADDR_WIDTH   = 19,
    parameter int READ_LATENCY = 2
) (
    input  logic        iClk,
    input  logic        iRst,
    pp_stream_if.slave  sin,
    pp_stream_if.master sout,
    pp_bram_if.master   bram,
    output logic        oFrameDone
`ifdef BRAM_PP_FRAME_CNT_EN
    ,
    output logic [15:0] oFrameCnt
`endif
);

    localparam int FIFO_DEPTH = READ_LATENCY + 2;
    localparam int IDX_W      = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam int PTR_W      = $clog2(FIFO_DEPTH);
    localparam int CNT_W      = $clog2(FIFO_DEPTH + 1);
    localparam int SUM_W      = CNT_W + 1;
    localparam logic [IDX_W-1:0]      IDX_LAST   = IDX_W'(FRAME_LEN - 1);
    localparam logic [ADDR_WIDTH-1:0] BANK1_BASE = ADDR_WIDTH'(FRAME_LEN);

    localparam logic [1:0] R_IDLE  = 2'd0;
    localparam logic [1:0] R_RUN   = 2'd1;
    localparam logic [1:0] R_DRAIN = 2'd2;

    logic                    run_q;
    logic [1:0]              full_q, full_d;
    logic                    wr_bank_q, wr_bank_d, rd_bank_q, rd_bank_d;
    logic [IDX_W-1:0]        wr_idx_q, wr_idx_d, rd_idx_q, rd_idx_d;
    logic [IDX_W-1:0]        out_idx_q, out_idx_d;
    logic [1:0]              state_q, state_d;
    logic [READ_LATENCY-1:0] vld_q, vld_d;
    logic [DATA_WIDTH-1:0]   fifo_q [2**PTR_W];
    logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]        fifo_cnt_q, fifo_cnt_d;
    logic [CNT_W-1:0]        inflight_s;
    logic                    wr_fire_s, issue_s, push_s, pop_s, nonempty_s;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? PTR_W'(0) : p + PTR_W'(1);
    endfunction

    function automatic logic [CNT_W-1:0] count_ones(input logic [READ_LATENCY-1:0] v);
        logic [CNT_W-1:0] n;
        n = CNT_W'(0);
        for (int i = 0; i < READ_LATENCY; i++) n = n + CNT_W'(v[i]);
        return n;
    endfunction

    function automatic logic [ADDR_WIDTH-1:0] bank_addr(input logic bank, input logic [IDX_W-1:0] idx);
        return (bank ? BANK1_BASE : ADDR_WIDTH'(0)) + ADDR_WIDTH'(idx);
    endfunction

    // run_q holds oReady low while reset is asserted and for the first cycle after it
    assign sin.ready   = run_q & ~full_q[wr_bank_q];
    assign wr_fire_s   = sin.valid & sin.ready;
    assign inflight_s  = count_ones(vld_q);
    assign issue_s     = (state_q == R_RUN) &&
                         ((SUM_W'(fifo_cnt_q) + SUM_W'(inflight_s)) < SUM_W'(FIFO_DEPTH));
    assign push_s      = vld_q[READ_LATENCY-1];
    assign nonempty_s  = (fifo_cnt_q != CNT_W'(0));
    assign pop_s       = nonempty_s & sout.ready;

    assign bram.en_a    = wr_fire_s;
    assign bram.addr_a  = wr_fire_s ? bank_addr(wr_bank_q, wr_idx_q) : ADDR_WIDTH'(0);
    assign bram.din_a   = wr_fire_s ? sin.data : DATA_WIDTH'(0);
    assign bram.en_b    = issue_s;
    assign bram.regce_b = issue_s | (inflight_s != CNT_W'(0));
    assign bram.addr_b  = issue_s ? bank_addr(rd_bank_q, rd_idx_q) : ADDR_WIDTH'(0);

    assign sout.valid  = nonempty_s;
    assign sout.data   = nonempty_s ? fifo_q[rd_ptr_q] : DATA_WIDTH'(0);
    assign oFrameDone  = pop_s & (out_idx_q == IDX_LAST);

    // Write side, bank bookkeeping and read FSM next state
    always_comb begin
        full_d    = full_q;
        wr_bank_d = wr_bank_q;
        wr_idx_d  = wr_idx_q;
        rd_bank_d = rd_bank_q;
        rd_idx_d  = rd_idx_q;
        state_d   = state_q;

        if (wr_fire_s) begin
            if (wr_idx_q == IDX_LAST) begin
                wr_idx_d          = IDX_W'(0);
                full_d[wr_bank_q] = 1'b1;
                wr_bank_d         = ~wr_bank_q;
            end else begin
                wr_idx_d = wr_idx_q + IDX_W'(1);
            end
        end else begin
            wr_idx_d = wr_idx_q;
        end

        // A completing write and a releasing drain always target different banks
        case (state_q)
            R_IDLE: begin
                if (full_q[rd_bank_q]) state_d = R_RUN;
                else                   state_d = R_IDLE;
            end
            R_RUN: begin
                if (issue_s) begin
                    if (rd_idx_q == IDX_LAST) begin
                        rd_idx_d = IDX_W'(0);
                        state_d  = R_DRAIN;
                    end else begin
                        rd_idx_d = rd_idx_q + IDX_W'(1);
                    end
                end else begin
                    rd_idx_d = rd_idx_q;
                end
            end
            R_DRAIN: begin
                if (inflight_s == CNT_W'(0)) begin
                    full_d[rd_bank_q] = 1'b0;
                    rd_bank_d         = ~rd_bank_q;
                    state_d           = R_IDLE;
                end else begin
                    state_d = R_DRAIN;
                end
            end
            default: state_d = R_IDLE;
        endcase
    end

    // Read-data tracking and output FIFO pointers
    always_comb begin
        vld_d    = (vld_q << 1) | READ_LATENCY'(issue_s);
        wr_ptr_d = push_s ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop_s ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        case ({push_s, pop_s})
            2'b10:   fifo_cnt_d = fifo_cnt_q + CNT_W'(1);
            2'b01:   fifo_cnt_d = fifo_cnt_q - CNT_W'(1);
            default: fifo_cnt_d = fifo_cnt_q;
        endcase
        if (pop_s) begin
            out_idx_d = (out_idx_q == IDX_LAST) ? IDX_W'(0) : out_idx_q + IDX_W'(1);
        end else begin
            out_idx_d = out_idx_q;
        end
    end

    // Control state registers
    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            run_q      <= 1'b0;
            full_q     <= 2'b00;
            wr_bank_q  <= 1'b0;
            rd_bank_q  <= 1'b0;
            wr_idx_q   <= IDX_W'(0);
            rd_idx_q   <= IDX_W'(0);
            out_idx_q  <= IDX_W'(0);
            state_q    <= R_IDLE;
            vld_q      <= READ_LATENCY'(0);
            wr_ptr_q   <= PTR_W'(0);
            rd_ptr_q   <= PTR_W'(0);
            fifo_cnt_q <= CNT_W'(0);
        end else begin
            run_q      <= 1'b1;
            full_q     <= full_d;
            wr_bank_q  <= wr_bank_d;
            rd_bank_q  <= rd_bank_d;
            wr_idx_q   <= wr_idx_d;
            rd_idx_q   <= rd_idx_d;
            out_idx_q  <= out_idx_d;
            state_q    <= state_d;
            vld_q      <= vld_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            fifo_cnt_q <= fifo_cnt_d;
        end
    end

    // Output FIFO storage, written with BRAM data READ_LATENCY cycles after issue
    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            for (int i = 0; i < 2**PTR_W; i++) fifo_q[i] <= DATA_WIDTH'(0);
        end else if (push_s) begin
            fifo_q[wr_ptr_q] <= bram.dout_b;
        end else begin
            fifo_q[wr_ptr_q] <= fifo_q[wr_ptr_q];
        end
    end

`ifdef BRAM_PP_FRAME_CNT_EN
    logic [15:0] frame_cnt_q;

    // Completed-frame counter, wraps naturally at 16 bits
    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            frame_cnt_q <= 16'd0;
        end else if (oFrameDone) begin
            frame_cnt_q <= frame_cnt_q + 16'd1;
        end else begin
            frame_cnt_q <= frame_cnt_q;
        end
    end

    assign oFrameCnt = frame_cnt_q;
`endif

endmodule

// File: tb/tb_bram_pingpong_ctrl.sv
// Bench for bram_pingpong_ctrl: two instances (READ_LATENCY 1 and 2) driven side by side,
// each with its own BRAM model, checked against a sample-queue reference model.
module tb_bram_pingpong_ctrl;

    localparam int DW = 8;
    localparam int FL = 100;
    localparam int AW = 19;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic          in_valid [2];
    logic          in_ready [2];
    logic [DW-1:0] in_data  [2];
    logic          out_valid[2];
    logic          out_ready[2];
    logic [DW-1:0] out_data [2];
    logic          frame_done[2];
    logic          en_a[2], en_b[2], regce_b[2];
    logic [AW-1:0] addr_a[2], addr_b[2];
    logic [DW-1:0] din_a[2];
`ifdef BRAM_PP_FRAME_CNT_EN
    logic [15:0]   frame_cnt[2];
`endif

    for (genvar g = 0; g < 2; g++) begin : gi
        pp_stream_if #(.DATA_WIDTH(DW)) s_in ();
        pp_stream_if #(.DATA_WIDTH(DW)) s_out ();
        pp_bram_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bram ();
        logic [DW-1:0] mem [0:255];
        logic [DW-1:0] st1, st2;

        assign s_in.valid     = in_valid[g];
        assign s_in.data      = in_data[g];
        assign in_ready[g]    = s_in.ready;
        assign out_valid[g]   = s_out.valid;
        assign out_data[g]    = s_out.data;
        assign s_out.ready    = out_ready[g];
        assign en_a[g]        = bram.en_a;
        assign en_b[g]        = bram.en_b;
        assign regce_b[g]     = bram.regce_b;
        assign addr_a[g]      = bram.addr_a;
        assign addr_b[g]      = bram.addr_b;
        assign din_a[g]       = bram.din_a;
        assign bram.dout_b    = (g == 0) ? st1 : st2;

        bram_pingpong_ctrl #(.DATA_WIDTH(DW), .FRAME_LEN(FL), .ADDR_WIDTH(AW),
                             .READ_LATENCY(g + 1)) dut (
            .iClk(clk), .iRst(rst_n), .sin(s_in), .sout(s_out), .bram(bram),
            .oFrameDone(frame_done[g])
`ifdef BRAM_PP_FRAME_CNT_EN
            , .oFrameCnt(frame_cnt[g])
`endif
        );

        always @(posedge clk) begin
            if (bram.en_a) mem[bram.addr_a[7:0]] <= bram.din_a;
            if (bram.en_b) st1 <= mem[bram.addr_b[7:0]];
            if (bram.regce_b) st2 <= st1;
        end
    end

    typedef struct {
        int n;
        int vpct;
        int rpct;
        bit seq;
        int exp_out;
        int exp_done;
    } row_t;

    row_t rows[5];
    row_t fresh;

    int checks = 0;
    int passed = 0;
    int sent[2], out_n[2], rd_n[2], dones[2], tgt[2];
    logic [DW-1:0] nxt[2];
    logic          hold_v[2];
    logic [DW-1:0] hold_d[2];
    logic [DW-1:0] q0[$];
    logic [DW-1:0] q1[$];
    int  vpct, rpct;
    bit  seq_mode;

    function automatic void chk(string nm, int k, longint act, longint exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s[inst %0d]: got %0h, expected %0h", nm, k, act, exp);
    endfunction

    function automatic int exp_addr(int n);
        return ((n / FL) % 2) * FL + (n % FL);
    endfunction

    function automatic void model_reset();
        for (int k = 0; k < 2; k++) begin
            sent[k] = 0; out_n[k] = 0; rd_n[k] = 0; dones[k] = 0; tgt[k] = 0;
            hold_v[k] = 1'b0; hold_d[k] = '0;
        end
        q0.delete();
        q1.delete();
    endfunction

    function automatic logic [DW-1:0] fresh_data(int k);
        return seq_mode ? DW'(sent[k]) : DW'($urandom);
    endfunction

    task automatic step();
        bit fire, pop;
        logic [DW-1:0] e;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            in_valid[k]  = (sent[k] < tgt[k]) && (int'($urandom_range(99)) < vpct);
            in_data[k]   = nxt[k];
            out_ready[k] = (int'($urandom_range(99)) < rpct);
        end
        #1;
        for (int k = 0; k < 2; k++) begin
            fire = in_valid[k] & in_ready[k];
            chk("en_a", k, en_a[k], fire);
            if (fire) begin
                chk("addr_a", k, addr_a[k], exp_addr(sent[k]));
                chk("din_a", k, din_a[k], in_data[k]);
                if (k == 0) q0.push_back(in_data[k]); else q1.push_back(in_data[k]);
                sent[k]++;
                nxt[k] = fresh_data(k);
            end
            if (en_b[k]) begin
                chk("addr_b", k, addr_b[k], exp_addr(rd_n[k]));
                chk("regce_b", k, regce_b[k], 1);
                rd_n[k]++;
            end
            if (hold_v[k]) begin
                chk("hold_valid", k, out_valid[k], 1);
                chk("hold_data", k, out_data[k], hold_d[k]);
            end
            pop = out_valid[k] & out_ready[k];
            if (pop) begin
                if ((k == 0 ? q0.size() : q1.size()) == 0) begin
                    chk("pop_unexpected", k, 1, 0);
                end else begin
                    e = (k == 0) ? q0.pop_front() : q1.pop_front();
                    chk("out_data", k, out_data[k], e);
                    chk("frame_done", k, frame_done[k], (out_n[k] % FL) == FL - 1);
                    if (frame_done[k]) dones[k]++;
                    out_n[k]++;
                end
            end else begin
                chk("frame_done_idle", k, frame_done[k], 0);
            end
            hold_v[k] = out_valid[k] & ~out_ready[k];
            hold_d[k] = out_data[k];
        end
    endtask

    task automatic check_reset_state();
        for (int k = 0; k < 2; k++) begin
            chk("rst_ready", k, in_ready[k], 0);
            chk("rst_valid", k, out_valid[k], 0);
            chk("rst_data", k, out_data[k], 0);
            chk("rst_done", k, frame_done[k], 0);
            chk("rst_en", k, {en_a[k], en_b[k], regce_b[k]}, 0);
            chk("rst_addr", k, {addr_a[k], addr_b[k], din_a[k]}, 0);
`ifdef BRAM_PP_FRAME_CNT_EN
            chk("rst_frame_cnt", k, frame_cnt[k], 0);
`endif
        end
    endtask

    task automatic run_row(row_t r);
        int s0[2], o0[2], d0[2];
        int cyc;
        seq_mode = r.seq;
        for (int k = 0; k < 2; k++) begin
            s0[k] = sent[k]; o0[k] = out_n[k]; d0[k] = dones[k];
            tgt[k] = sent[k] + r.n;
            nxt[k] = fresh_data(k);
        end
        vpct = r.vpct; rpct = r.rpct;
        cyc = 0;
        while (!((out_n[0] - o0[0] >= r.n) && (out_n[1] - o0[1] >= r.n)) && cyc < 20000) begin
            step();
            cyc++;
        end
        vpct = 0; rpct = 100;
        repeat (20) step();
        for (int k = 0; k < 2; k++) begin
            chk("row_in", k, sent[k] - s0[k], r.n);
            chk("row_out", k, out_n[k] - o0[k], r.exp_out);
            chk("row_done", k, dones[k] - d0[k], r.exp_done);
`ifdef BRAM_PP_FRAME_CNT_EN
            chk("frame_cnt", k, frame_cnt[k], out_n[k] / FL);
`endif
        end
    endtask

    initial begin
        rows[0] = '{n: 100, vpct: 100, rpct: 100, seq: 1'b1, exp_out: 100, exp_done: 1};
        rows[1] = '{n: 300, vpct: 100, rpct: 100, seq: 1'b0, exp_out: 300, exp_done: 3};
        rows[2] = '{n: 400, vpct: 50,  rpct: 50,  seq: 1'b0, exp_out: 400, exp_done: 4};
        rows[3] = '{n: 200, vpct: 90,  rpct: 30,  seq: 1'b0, exp_out: 200, exp_done: 2};
        rows[4] = '{n: 300, vpct: 30,  rpct: 90,  seq: 1'b1, exp_out: 300, exp_done: 3};
        fresh   = '{n: 100, vpct: 100, rpct: 100, seq: 1'b1, exp_out: 100, exp_done: 1};

        for (int k = 0; k < 2; k++) begin
            in_valid[k] = 1'b0; in_data[k] = '0; out_ready[k] = 1'b0; nxt[k] = '0;
        end
        seq_mode = 1'b1;
        model_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check_reset_state();
        @(negedge clk);
        rst_n = 1'b1;

        for (int r = 0; r < 5; r++) run_row(rows[r]);

        // Downstream stalled: both banks fill, then the writer must back off
        begin
            int s0[2], o0[2], d0[2];
            logic [DW-1:0] first[2];
            int cyc;
            seq_mode = 1'b1;
            for (int k = 0; k < 2; k++) begin
                s0[k] = sent[k]; o0[k] = out_n[k]; d0[k] = dones[k];
                tgt[k] = sent[k] + 250;
                nxt[k] = fresh_data(k);
                first[k] = nxt[k];
            end
            vpct = 100; rpct = 0;
            repeat (400) step();
            for (int k = 0; k < 2; k++) begin
                chk("stall_accepted", k, sent[k] - s0[k], 200);
                chk("stall_ready", k, in_ready[k], 0);
                chk("stall_valid", k, out_valid[k], 1);
                chk("stall_head", k, out_data[k], first[k]);
                tgt[k] = s0[k] + 300;
            end
            rpct = 100;
            cyc = 0;
            while (!((out_n[0] - o0[0] >= 300) && (out_n[1] - o0[1] >= 300)) && cyc < 5000) begin
                step();
                cyc++;
            end
            vpct = 0;
            repeat (20) step();
            for (int k = 0; k < 2; k++) begin
                chk("stall_out", k, out_n[k] - o0[k], 300);
                chk("stall_done", k, dones[k] - d0[k], 3);
            end
        end

        // Reset in the middle of the second frame, then one clean frame
        begin
            int s0;
            int cyc;
            seq_mode = 1'b0;
            s0 = sent[0];
            for (int k = 0; k < 2; k++) begin
                tgt[k] = sent[k] + 300;
                nxt[k] = fresh_data(k);
            end
            vpct = 100; rpct = 100;
            cyc = 0;
            while (sent[0] - s0 < 157 && cyc < 2000) begin
                step();
                cyc++;
            end
            chk("pre_reset_count", 0, sent[0] - s0, 157);
            @(negedge clk);
            rst_n = 1'b0;
            for (int k = 0; k < 2; k++) in_valid[k] = 1'b0;
            @(negedge clk);
            #1;
            check_reset_state();
            model_reset();
            @(negedge clk);
            rst_n = 1'b1;
            run_row(fresh);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
